// File: rtl/shift_cap_pkg.sv
// Shared constants and types for the shift-register capture FIFO.
// Defaults here match the top-level parameter defaults.
package shift_cap_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int DEPTH_DEF      = 4;
    localparam int PTR_W          = $clog2(DEPTH_DEF);
    localparam int CNT_W          = PTR_W + 1;
    localparam int CHG_W          = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

endpackage

// File: rtl/shift_cap_fifo_core.sv
// Circular-buffer FIFO: storage, wrapping pointers and occupancy count.
// Storage is deliberately left unreset; only pointers and count clear.
module shift_cap_fifo_core
    import shift_cap_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  push_ok;
    logic                  pop_ok;
    occ_e                  occ;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0)
            occ = OCC_EMPTY;
        else if (count == CW'(DEPTH))
            occ = OCC_FULL;
    end

    assign empty = (occ == OCC_EMPTY);
    assign full  = (occ == OCC_FULL);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + PW'(1);
            if (pop_ok)
                rptr <= rptr + PW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/shift_capture_fifo.sv
// Captures shift-register words into a FIFO only when the word changes,
// with a sticky overflow flag and a saturating change counter.
module shift_capture_fifo
    import shift_cap_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    cap_en,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    input  logic                    clr_ovf,
    output logic [CHG_W-1:0]        change_cnt
);

    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_valid;
    logic                  change;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  drop;

    assign change  = cap_en && (!prev_valid || data_in != prev);
    assign m_valid = !empty;
    assign pop     = m_valid && m_ready;
    assign drop    = change && full && !pop;

    shift_cap_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .push  (change),
        .pop   (pop),
        .wdata (data_in),
        .rdata (m_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (cap_en) begin
            prev       <= data_in;
            prev_valid <= 1'b1;
        end
    end

    // Set has priority so a drop in the clearing cycle is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            change_cnt <= '0;
        else if (change && change_cnt != '1)
            change_cnt <= change_cnt + CHG_W'(1);
    end

endmodule

// File: doc/shift_capture_fifo.md
SHIFT_CAPTURE_FIFO -- requirements
Module: shift_capture_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4: width of each captured word; equals the width of the upstream shift-register parallel output.
REQ-002 The block SHALL have parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 data_in  input  DATA_WIDTH  parallel word from the shift register's data_out, sampled every clk rising edge.
REQ-006 cap_en  input  1  capture enable; change detection and capture occur only while high.
REQ-007 m_data  output  DATA_WIDTH  word at the FIFO head.
REQ-008 m_valid  output  1  FIFO non-empty; m_data is valid.
REQ-009 m_ready  input  1  consumer accepts the head word when high with m_valid.
REQ-010 count  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-011 overflow  output  1  sticky flag: a word was dropped because the FIFO was full.
REQ-012 clr_ovf  input  1  synchronous clear of overflow.
REQ-013 change_cnt  output  8  detected-change counter, saturating at 255.

Function
REQ-014 A change SHALL be detected at a rising edge when cap_en=1 and either prev_valid=0 or data_in != prev.
REQ-015 When cap_en=1, prev SHALL load data_in and prev_valid SHALL set to 1 at every edge, whether or not the push succeeds; when cap_en=0, prev and prev_valid SHALL hold.
REQ-016 A detected change SHALL push data_in into the FIFO at the same edge; m_valid SHALL be high in the following cycle (latency 1 cycle).
REQ-017 A pop SHALL occur at an edge where m_valid=1 and m_ready=1; m_data SHALL be combinational from the head entry (no added latency).
REQ-018 FIFO occupancy states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH); count SHALL be +1 on push only, -1 on pop only, and unchanged on push+pop.
REQ-019 A push when FULL with no pop in the same cycle SHALL drop the word, leave FIFO contents unchanged, and set overflow.
REQ-020 A push when FULL with a simultaneous pop SHALL succeed on both; count SHALL stay DEPTH and overflow SHALL not set.
REQ-021 Push and pop in the same cycle when EMPTY SHALL not occur: the pop requires m_valid=1, so only the push takes effect.
REQ-022 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 change_cnt SHALL increment on every detected change, including dropped ones, and SHALL hold at 255.
REQ-024 clr_ovf=1 SHALL clear overflow at the next edge; if an overflow event occurs at that same edge, set SHALL win.

Reset
REQ-025 While rst=1, the block SHALL force asynchronously: pointers=0, count=0, m_valid=0, overflow=0, change_cnt=0, prev=0, prev_valid=0.
REQ-026 FIFO storage SHALL not be reset; m_data is don't-care while m_valid=0.
REQ-027 Reset asserted mid-operation SHALL discard all queued words; the first word captured after release SHALL be treated as a change.

Structure
REQ-028 Package shift_cap_pkg SHALL hold DATA_WIDTH and DEPTH defaults, PTR_W=$clog2(DEPTH), CNT_W=PTR_W+1, and the change_cnt width constant 8.
REQ-029 Storage and pointers SHALL be in one sub-module, shift_cap_fifo_core (push/pop/full/empty/count); change detection, overflow and change_cnt SHALL be in the top.

Verification
REQ-030 The bench SHALL cover: rst pulse, then cap_en=1, data_in held at 4'h5 for 5 cycles, m_ready=0 -> exactly 1 push, count=1, m_data=4'h5, change_cnt=1.
REQ-031 The bench SHALL cover: data_in sequence 1,2,2,3,3,3,4 with cap_en=1 and m_ready=0 -> FIFO holds 1,2,3,4, count=4, overflow=0.
REQ-032 The bench SHALL cover: FIFO full, then data_in=4'h9 with m_ready=0 -> word dropped, overflow=1, change_cnt +1; repeat with m_ready=1 -> pop 1 + push 9, count stays 4, no overflow.
REQ-033 The bench SHALL cover: clr_ovf=1 in the same cycle as a dropped push -> overflow stays 1; clr_ovf=1 in a quiet cycle -> overflow=0.
REQ-034 The bench SHALL cover: cap_en=0 while data_in changes 6->7, then cap_en=1 with data_in=7 and prev=6 -> one push of 7.
REQ-035 The bench SHALL cover: rst asserted mid-clock with count=3 -> m_valid=0 and count=0 immediately, before the next clk edge.
